// File: rtl/dcache_wt_if.sv
// Cache-to-main-memory request/acknowledge bus; the cache is master, memory is slave.
interface dcache_wt_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_adr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_adr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate D-cache: read hits in 0 cycles,
// misses and stores stall the M stage (2 + memory wait cycles) until mem_ready.
module dcache_wt #(
  parameter int NSETS = 16,
  parameter int IDXW  = $clog2(NSETS)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memreadM,
  input  logic         memwriteM,
  input  logic [31:0]  adrM,
  input  logic [31:0]  writedataM,
  output logic [31:0]  readdataM,
  output logic         stallM,
  dcache_wt_if.master  mem
);

  localparam int TAGW = 30 - IDXW;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t            state_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [31:0]       mem_adr_q;
  logic [31:0]       mem_wdata_q;
  logic              done_q;

  logic [NSETS-1:0]  valid_q;
  logic [TAGW-1:0]   tag_q  [NSETS];
  logic [31:0]       data_q [NSETS];

  logic [IDXW-1:0]   idx;
  logic [TAGW-1:0]   tag;
  logic [IDXW-1:0]   fill_idx;
  logic [TAGW-1:0]   fill_tag;
  logic              tag_match;
  logic              fill_ack;
  logic              store_go;
  logic              adr_lo_unused;

  assign idx           = adrM[IDXW+1:2];
  assign tag           = adrM[31:IDXW+2];
  assign fill_idx      = mem_adr_q[IDXW+1:2];
  assign fill_tag      = mem_adr_q[31:IDXW+2];
  assign tag_match     = valid_q[idx] && (tag_q[idx] == tag);
  assign fill_ack      = (state_q == FILL) && mem.mem_ready;
  // A store is issued once; the replay after its ack only releases the stall.
  assign store_go      = (state_q == IDLE) && memwriteM && !done_q;
  assign adr_lo_unused = ^adrM[1:0];

  always_comb begin
    readdataM = '0;
    stallM    = 1'b0;
    case (state_q)
      IDLE: begin
        if (memwriteM) begin
          stallM = !done_q;
        end else if (memreadM) begin
          if (tag_match) readdataM = data_q[idx];
          else           stallM    = 1'b1;
        end
      end
      default: stallM = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (store_go) begin
            state_q     <= WRITE;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_adr_q   <= {adrM[31:2], 2'b00};
            mem_wdata_q <= writedataM;
          end else if (memreadM && !memwriteM && !tag_match) begin
            state_q   <= FILL;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b0;
            mem_adr_q <= {adrM[31:2], 2'b00};
          end
        end
        FILL: begin
          if (mem.mem_ready) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end
        end
        WRITE: begin
          if (mem.mem_ready) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (fill_ack) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag/data storage is never reset; reset only blocks writes so an aborted fill leaves no trace.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fill_ack) begin
        tag_q[fill_idx]  <= fill_tag;
        data_q[fill_idx] <= mem.mem_rdata;
      end else if (store_go && tag_match) begin
        data_q[idx] <= writedataM;
      end
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_adr   = mem_adr_q;
  assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dcache_wt.sv
// Bench for dcache_wt: vector table of loads/stores against a latency-programmable memory model.
module tb_dcache_wt;

  logic        clk = 1'b0;
  logic        reset;
  logic        memreadM;
  logic        memwriteM;
  logic [31:0] adrM;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic        stallM;

  dcache_wt_if mem ();

  dcache_wt #(.NSETS(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .memreadM   (memreadM),
    .memwriteM  (memwriteM),
    .adrM       (adrM),
    .writedataM (writedataM),
    .readdataM  (readdataM),
    .stallM     (stallM),
    .mem        (mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          lat;
    logic [31:0] exp_rd;
    int          exp_stall;
    logic        exp_req;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
  } mtx_t;

  vec_t        vecs [18];
  mtx_t        mq [$];
  logic [31:0] rq [$];
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] adr,
                              input logic [31:0] wdata, input logic [31:0] mrdata, input int lat,
                              input logic [31:0] exp_rd, input int exp_stall, input logic exp_req);
    vec_t v;
    v.rd = rd; v.wr = wr; v.adr = adr; v.wdata = wdata; v.mrdata = mrdata; v.lat = lat;
    v.exp_rd = exp_rd; v.exp_stall = exp_stall; v.exp_req = exp_req;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int   stalls;
    int   req_cycles;
    bit   seen;
    bit   done;
    mtx_t m;
    logic [31:0] e;
    @(negedge clk);
    memreadM      = v.rd;
    memwriteM     = v.wr;
    adrM          = v.adr;
    writedataM    = v.wdata;
    mem.mem_ready = 1'b0;
    rq.push_back(v.exp_rd);
    if (v.exp_req) begin
      m.we = v.wr; m.adr = {v.adr[31:2], 2'b00}; m.wdata = v.wdata;
      mq.push_back(m);
    end
    stalls = 0; req_cycles = 0; seen = 0; done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      if (mem.mem_req) begin
        if (!seen && mq.size() != 0) begin
          m = mq.pop_front();
          chk({tag, " mem_we"}, 32'(mem.mem_we), 32'(m.we));
          chk({tag, " mem_adr"}, mem.mem_adr, m.adr);
          if (m.we) chk({tag, " mem_wdata"}, mem.mem_wdata, m.wdata);
        end
        seen          = 1;
        mem.mem_ready = (req_cycles == v.lat);
        mem.mem_rdata = v.mrdata;
        req_cycles++;
      end else begin
        mem.mem_ready = 1'b0;
      end
      #1;
      if (!stallM) begin
        done = 1;
        e    = rq.pop_front();
        chk({tag, " readdataM"}, readdataM, e);
      end else begin
        stalls++;
        @(negedge clk);
      end
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL %s stall timeout: still stalled after 64 cycles, required release", tag);
      void'(rq.pop_front());
    end
    chk({tag, " stall cycles"}, 32'(stalls), 32'(v.exp_stall));
    chk({tag, " mem_req issued"}, 32'(seen), 32'(v.exp_req));
    mq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rd    wr    adr    wdata     mrdata    lat  exp_rd    stall req
    vecs[0]  = mk(1'b1, 1'b0, 32'h40, 32'h0,    32'h7,    0, 32'h7,    2, 1'b1);
    vecs[1]  = mk(1'b1, 1'b0, 32'h40, 32'h0,    32'h0,    0, 32'h7,    0, 1'b0);
    vecs[2]  = mk(1'b1, 1'b0, 32'h80, 32'h0,    32'h9,    2, 32'h9,    4, 1'b1);
    vecs[3]  = mk(1'b1, 1'b0, 32'h40, 32'h0,    32'h7,    1, 32'h7,    3, 1'b1);
    vecs[4]  = mk(1'b0, 1'b1, 32'h54, 32'hDEAD, 32'h0,    3, 32'h0,    5, 1'b1);
    vecs[5]  = mk(1'b1, 1'b0, 32'h54, 32'h0,    32'h1234, 0, 32'h1234, 2, 1'b1);
    vecs[6]  = mk(1'b1, 1'b0, 32'h80, 32'h0,    32'h9,    0, 32'h9,    2, 1'b1);
    vecs[7]  = mk(1'b0, 1'b1, 32'h80, 32'h5,    32'h0,    1, 32'h0,    3, 1'b1);
    vecs[8]  = mk(1'b1, 1'b0, 32'h80, 32'h0,    32'hEE,   0, 32'h5,    0, 1'b0);
    vecs[9]  = mk(1'b1, 1'b0, 32'h83, 32'h0,    32'hEE,   0, 32'h5,    0, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 32'h80, 32'h0,    32'h0,    0, 32'h0,    0, 1'b0);
    vecs[11] = mk(1'b1, 1'b1, 32'h44, 32'hBEEF, 32'h0,    0, 32'h0,    2, 1'b1);
    vecs[12] = mk(1'b1, 1'b0, 32'h97, 32'h0,    32'h55,   0, 32'h55,   2, 1'b1);
    vecs[13] = mk(1'b1, 1'b0, 32'h94, 32'h0,    32'hEE,   0, 32'h55,   0, 1'b0);
    vecs[14] = mk(1'b1, 1'b0, 32'h40, 32'h0,    32'h66,   0, 32'h66,   2, 1'b1);
    vecs[15] = mk(1'b1, 1'b0, 32'h40, 32'h0,    32'hEE,   0, 32'h66,   0, 1'b0);
    vecs[16] = mk(1'b1, 1'b0, 32'hC0, 32'h0,    32'h31,   1, 32'h31,   3, 1'b1);
    vecs[17] = mk(1'b1, 1'b0, 32'h94, 32'h0,    32'h55,   0, 32'h55,   2, 1'b1);

    reset = 1'b1; memreadM = 1'b0; memwriteM = 1'b0; adrM = '0; writedataM = '0;
    mem.mem_ready = 1'b0; mem.mem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset stallM", 32'(stallM), 32'h0);
    chk("reset readdataM", readdataM, 32'h0);
    chk("reset mem_req", 32'(mem.mem_req), 32'h0);
    chk("reset mem_we", 32'(mem.mem_we), 32'h0);
    chk("reset mem_adr", mem.mem_adr, 32'h0);
    chk("reset mem_wdata", mem.mem_wdata, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Reset lands while a fill is outstanding, with an ack arriving on the reset edge.
    @(negedge clk);
    memreadM = 1'b1; memwriteM = 1'b0; adrM = 32'hC0; mem.mem_ready = 1'b0;
    for (int c = 0; c < 10 && !mem.mem_req; c++) @(negedge clk);
    chk("abort fill started", 32'(mem.mem_req), 32'h1);
    reset = 1'b1; mem.mem_ready = 1'b1; mem.mem_rdata = 32'hBAD;
    @(negedge clk);
    #1;
    chk("abort mem_req dropped", 32'(mem.mem_req), 32'h0);
    chk("abort mem_we", 32'(mem.mem_we), 32'h0);
    reset = 1'b0; memreadM = 1'b0;
    @(negedge clk);
    #1;
    chk("stray ready mem_req", 32'(mem.mem_req), 32'h0);
    chk("stray ready stallM", 32'(stallM), 32'h0);
    mem.mem_ready = 1'b0;

    for (int i = 14; i < 18; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    @(negedge clk);
    memreadM = 1'b0; memwriteM = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
